// File: rtl/mem_lsu.sv
// Load/store unit between the core execute stage and a word-addressed,
// read-registered data memory. Byte-addressed byte/halfword/word requests
// become word-index accesses. Loads are sign- or zero-extended. Sub-word
// stores are done as read-modify-write. Misaligned and out-of-range
// requests are answered with an error and never touch memory.
// Exactly one request is in flight at a time. Responses are one-cycle
// pulses with no backpressure.
module mem_lsu #(
    parameter int XLEN      = 32,
    parameter int MEM_WORDS = 1024
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_we_i,
    input  logic [1:0]      req_size_i,
    input  logic            req_unsigned_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    output logic            rsp_valid_o,
    output logic [XLEN-1:0] rsp_rdata_o,
    output logic            rsp_err_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic [XLEN-1:0] mem_rdata_i
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_DATA,
        S_WR,
        S_RESP
    } state_t;

    // Request fields captured at acceptance. They stay stable for the whole access.
    typedef struct packed {
        logic            we;
        logic [1:0]      size;
        logic            uns;
        logic [1:0]      off;    // byte offset within the word
        logic [XLEN-1:0] widx;   // word index presented to memory
        logic [XLEN-1:0] wdata;
    } req_t;

    state_t          state;
    req_t            cap;

    logic [XLEN-1:0] req_widx;
    logic            req_err;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic [XLEN-1:0] ld_data;
    logic [XLEN-1:0] st_merge;

    assign req_widx    = req_addr_i >> 2;
    assign req_ready_o = (state == S_IDLE);
    assign mem_addr_o  = cap.widx;

    // Reject illegal size, misalignment and indexes beyond the memory at acceptance.
    always_comb begin
        req_err = 1'b0;
        case (req_size_i)
            SZ_ILL:  req_err = 1'b1;
            SZ_HALF: req_err = req_addr_i[0];
            SZ_WORD: req_err = (req_addr_i[1:0] != 2'b00);
            default: req_err = 1'b0;
        endcase
        if (req_widx >= XLEN'(MEM_WORDS))
            req_err = 1'b1;
    end

    // Pick the addressed little-endian lane from the returned word and extend it.
    always_comb begin
        rd_byte = mem_rdata_i[{cap.off, 3'b000} +: 8];
        rd_half = mem_rdata_i[{cap.off[1], 4'b0000} +: 16];
        case (cap.size)
            SZ_BYTE: ld_data = cap.uns ? {{(XLEN-8){1'b0}}, rd_byte}
                                       : {{(XLEN-8){rd_byte[7]}}, rd_byte};
            SZ_HALF: ld_data = cap.uns ? {{(XLEN-16){1'b0}}, rd_half}
                                       : {{(XLEN-16){rd_half[15]}}, rd_half};
            default: ld_data = mem_rdata_i;
        endcase
    end

    // Read-modify-write merge: the old word with only the target lane replaced.
    always_comb begin
        st_merge = mem_rdata_i;
        case (cap.size)
            SZ_BYTE: st_merge[{cap.off, 3'b000} +: 8]      = cap.wdata[7:0];
            SZ_HALF: st_merge[{cap.off[1], 4'b0000} +: 16] = cap.wdata[15:0];
            default: st_merge = mem_rdata_i;
        endcase
    end

    // Writes happen in WR and in the RD_DATA cycle of a sub-word store.
    // Reset gates the write at once, so an aborted access never reaches memory.
    always_comb begin
        mem_we_o    = rst_n_i & ((state == S_WR) | ((state == S_RD_DATA) & cap.we));
        mem_wdata_o = (state == S_RD_DATA) ? st_merge : cap.wdata;
    end

    // Access sequencer. The response registers are set on entering RESP and cleared on leaving it.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state       <= S_IDLE;
            cap         <= '0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        cap.we    <= req_we_i;
                        cap.size  <= req_size_i;
                        cap.uns   <= req_unsigned_i;
                        cap.off   <= req_addr_i[1:0];
                        cap.widx  <= req_widx;
                        cap.wdata <= req_wdata_i;
                        if (req_err) begin
                            state       <= S_RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b1;
                            rsp_rdata_o <= '0;
                        end else if (req_we_i && (req_size_i == SZ_WORD)) begin
                            state <= S_WR;
                        end else begin
                            state <= S_RD_REQ;
                        end
                    end
                end
                S_RD_REQ: state <= S_RD_DATA;
                S_RD_DATA: begin
                    state       <= S_RESP;
                    rsp_valid_o <= 1'b1;
                    rsp_err_o   <= 1'b0;
                    rsp_rdata_o <= cap.we ? '0 : ld_data;
                end
                S_WR: begin
                    state       <= S_RESP;
                    rsp_valid_o <= 1'b1;
                    rsp_err_o   <= 1'b0;
                    rsp_rdata_o <= '0;
                end
                S_RESP: begin
                    state       <= S_IDLE;
                    rsp_valid_o <= 1'b0;
                    rsp_err_o   <= 1'b0;
                    rsp_rdata_o <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: a read-registered word memory and a request-level
// reference model. Each accepted request predicts its response, its
// latency and its memory write. One negedge process compares the DUT
// against that prediction on every cycle.
module tb_mem_lsu;

    localparam int XLEN = 32;
    localparam int MW   = 64;

    logic            clk_i = 1'b0;
    logic            rst_n_i = 1'b0;
    logic            req_valid_i = 1'b0;
    logic            req_ready_o;
    logic            req_we_i = 1'b0;
    logic [1:0]      req_size_i = 2'b00;
    logic            req_unsigned_i = 1'b0;
    logic [XLEN-1:0] req_addr_i = '0;
    logic [XLEN-1:0] req_wdata_i = '0;
    logic            rsp_valid_o;
    logic [XLEN-1:0] rsp_rdata_o;
    logic            rsp_err_o;
    logic            mem_we_o;
    logic [XLEN-1:0] mem_addr_o;
    logic [XLEN-1:0] mem_wdata_o;
    logic [XLEN-1:0] mem_rdata_i;

    always #5 clk_i = ~clk_i;

    mem_lsu #(.XLEN(XLEN), .MEM_WORDS(MW)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_size_i(req_size_i),
        .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i)
    );

    // Data memory: synchronous write and registered read.
    logic [31:0] ram [MW];
    logic        init_ram = 1'b1;
    always @(posedge clk_i) begin
        if (init_ram) begin
            for (int i = 0; i < MW; i++) ram[i] <= '0;
        end else if (mem_we_o && mem_addr_o < MW) begin
            ram[mem_addr_o] <= mem_wdata_o;
        end
        mem_rdata_i <= (mem_addr_o < MW) ? ram[mem_addr_o] : 32'h0;
    end

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int          acc;    // cycle right after the accept edge
        int          due;    // cycle in which rsp_valid_o must be high
        bit          wr;
        bit          err;
        logic [31:0] widx;
        logic [31:0] nword;
        logic [31:0] rdata;
    } exp_t;

    exp_t        q[$];
    logic [31:0] ref_mem [MW];
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;
    bit          chk_en = 1'b0;
    bit          in_abort = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h, want %h", nm, cyc, act, exp);
        end
    endtask

    // Per-cycle comparison against the oldest outstanding prediction.
    always @(negedge clk_i) begin
        exp_t f;
        bit   have, due_now, exp_we;
        if (chk_en) begin
            have = (q.size() > 0);
            if (have) f = q[0];
            if (!in_abort)
                chk("req_ready", 32'(req_ready_o), 32'(!(have && cyc >= f.acc)));
            due_now = have && (cyc == f.due);
            exp_we  = have && f.wr && (cyc == f.due - 1);
            chk("rsp_valid", 32'(rsp_valid_o), 32'(due_now));
            chk("mem_we", 32'(mem_we_o), 32'(exp_we));
            if (have && !f.err && cyc >= f.acc && cyc < f.due)
                chk("mem_addr", mem_addr_o, f.widx);
            if (exp_we)
                chk("mem_wdata", mem_wdata_o, f.nword);
            if (due_now) begin
                chk("rsp_rdata", rsp_rdata_o, f.rdata);
                chk("rsp_err", 32'(rsp_err_o), 32'(f.err));
                last_rdata = rsp_rdata_o;
                last_err   = rsp_err_o;
                void'(q.pop_front());
            end else begin
                chk("rsp_rdata_idle", rsp_rdata_o, 32'h0);
            end
        end
    end

    // Present one request (called at a negedge), wait for acceptance and
    // record what it must produce. Valid is left high for back-to-back use.
    task automatic do_req(input bit we, input logic [1:0] sz, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input bit push);
        exp_t        e;
        int          n;
        logic [31:0] w, sh, lane, mask;
        req_we_i = we; req_size_i = sz; req_unsigned_i = uns;
        req_addr_i = addr; req_wdata_i = wdata; req_valid_i = 1'b1;
        n = 0;
        while (!req_ready_o && n < 40) begin
            @(negedge clk_i);
            n++;
        end
        if (!req_ready_o) begin
            n_vec++; n_err++;
            $display("FAIL ready_timeout: got ready=0 after %0d cycles, want 1", n);
            req_valid_i = 1'b0;
            return;
        end
        e.acc = cyc + 1; e.widx = addr >> 2;
        e.wr = 1'b0; e.nword = '0; e.rdata = '0;
        e.err = (sz == 2'b11) || (sz == 2'b01 && addr[0]) ||
                (sz == 2'b10 && addr[1:0] != 2'b00) || ((addr >> 2) >= MW);
        if (e.err) begin
            e.due = e.acc;
        end else begin
            w  = ref_mem[e.widx];
            sh = (sz == 2'b00) ? 8 * addr[1:0] : 16 * addr[1];
            if (!we) begin
                if (sz == 2'b00) begin
                    lane = (w >> sh) & 32'hFF;
                    if (!uns && lane[7]) lane = lane | 32'hFFFF_FF00;
                end else if (sz == 2'b01) begin
                    lane = (w >> sh) & 32'hFFFF;
                    if (!uns && lane[15]) lane = lane | 32'hFFFF_0000;
                end else begin
                    lane = w;
                end
                e.rdata = lane;
                e.due   = e.acc + 2;
            end else if (sz == 2'b10) begin
                e.wr = 1'b1; e.nword = wdata; e.due = e.acc + 1;
            end else begin
                mask    = ((sz == 2'b00) ? 32'hFF : 32'hFFFF) << sh;
                e.wr    = 1'b1;
                e.nword = (w & ~mask) | ((wdata << sh) & mask);
                e.due   = e.acc + 2;
            end
        end
        if (push) begin
            q.push_back(e);
            if (e.wr) ref_mem[e.widx] = e.nword;
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic wait_done();
        int n = 0;
        while (q.size() != 0 && n < 40) begin
            @(negedge clk_i);
            n++;
        end
        if (q.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL rsp_timeout: got %0d responses pending, want 0", q.size());
            q.delete();
        end
        @(negedge clk_i);
    endtask

    task automatic req1(input bit we, input logic [1:0] sz, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
        do_req(we, sz, uns, addr, wdata, 1'b1);
        req_valid_i = 1'b0;
        wait_done();
    endtask

    task automatic chk_last(input string nm, input logic [31:0] rd, input bit err);
        chk(nm, last_rdata, rd);
        chk({nm, "_err"}, 32'(last_err), 32'(err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < MW; i++) ref_mem[i] = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_ready", 32'(req_ready_o), 32'h1);
        chk("reset_rsp_valid", 32'(rsp_valid_o), 32'h0);
        chk("reset_rsp_rdata", rsp_rdata_o, 32'h0);
        chk("reset_rsp_err", 32'(rsp_err_o), 32'h0);
        chk("reset_mem_we", 32'(mem_we_o), 32'h0);
        rst_n_i = 1'b1; init_ram = 1'b0; chk_en = 1'b1;
        @(negedge clk_i);

        // word store then word load
        req1(1, 2'b10, 0, 32'h10, 32'hDEADBEEF);
        req1(0, 2'b10, 0, 32'h10, 32'h0);
        chk_last("lw_10", 32'hDEADBEEF, 0);

        // byte lane store and loads
        req1(1, 2'b10, 0, 32'h10, 32'h11223344);
        req1(1, 2'b00, 0, 32'h11, 32'h555555AB);
        chk("sb_11_word", ram[4], 32'h1122AB44);
        req1(0, 2'b00, 0, 32'h11, 32'h0);
        chk_last("lb_11", 32'hFFFFFFAB, 0);
        req1(0, 2'b00, 1, 32'h11, 32'h0);
        chk_last("lbu_11", 32'h000000AB, 0);

        // halfword lanes
        req1(1, 2'b10, 0, 32'h10, 32'h80013344);
        req1(0, 2'b01, 0, 32'h12, 32'h0);
        chk_last("lh_12", 32'hFFFF8001, 0);
        req1(0, 2'b01, 1, 32'h12, 32'h0);
        chk_last("lhu_12", 32'h00008001, 0);
        req1(1, 2'b01, 0, 32'h10, 32'hAAAA7FFF);
        chk("sh_10_word", ram[4], 32'h80017FFF);
        req1(0, 2'b10, 1, 32'h10, 32'h0);
        chk_last("lw_10_b", 32'h80017FFF, 0);

        // rejected requests
        req1(0, 2'b10, 0, 32'h02, 32'h0);
        chk_last("lw_02", 32'h0, 1);
        req1(1, 2'b01, 0, 32'h13, 32'hFFFF);
        chk_last("sh_13", 32'h0, 1);
        req1(0, 2'b11, 0, 32'h00, 32'h0);
        chk_last("size11", 32'h0, 1);
        req1(0, 2'b10, 0, 32'(4 * MW), 32'h0);
        chk_last("lw_oor", 32'h0, 1);
        req1(1, 2'b10, 0, 32'(4 * MW), 32'h12345678);
        chk_last("sw_oor", 32'h0, 1);

        // last word in range
        req1(1, 2'b10, 0, 32'(4 * MW - 4), 32'hCAFEF00D);
        req1(0, 2'b00, 0, 32'(4 * MW - 1), 32'h0);
        chk_last("lb_top", 32'hFFFFFFCA, 0);

        // back-to-back with valid held high
        do_req(1, 2'b10, 0, 32'h20, 32'h00C0FFEE, 1'b1);
        do_req(0, 2'b01, 0, 32'h22, 32'h0, 1'b1);
        do_req(0, 2'b00, 0, 32'h20, 32'h0, 1'b1);
        do_req(0, 2'b10, 0, 32'h21, 32'h0, 1'b1);
        do_req(1, 2'b00, 0, 32'h21, 32'h80, 1'b1);
        do_req(0, 2'b10, 0, 32'h20, 32'h0, 1'b1);
        req_valid_i = 1'b0;
        wait_done();
        chk_last("b2b_lw_20", 32'h00C080EE, 0);

        // reset during RD_DATA of a byte store aborts it
        in_abort = 1'b1;
        do_req(1, 2'b00, 0, 32'h10, 32'h000000CD, 1'b0);
        req_valid_i = 1'b0;
        @(posedge clk_i);
        #1 rst_n_i = 1'b0;
        #1 chk("abort_mem_we", 32'(mem_we_o), 32'h0);
        @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        @(negedge clk_i);
        chk("abort_ready", 32'(req_ready_o), 32'h1);
        chk("abort_word", ram[4], 32'h80017FFF);
        in_abort = 1'b0;
        req1(0, 2'b10, 0, 32'h10, 32'h0);
        chk_last("lw_after_abort", 32'h80017FFF, 0);

        for (int i = 0; i < MW; i++) chk("final_mem", ram[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
